// File: rtl/adder_tree_accum_array.sv
// Per-channel pipelined pairwise adder trees feeding a shared group accumulator.
// Groups close on in_last or after MAX_PASSES beats; results use a valid/ready handshake.
module adder_tree_accum_array #(
  parameter int ROW_WIDTH    = 10,
  parameter int COLUMN_WIDTH = 9,
  parameter int MAC_WIDTH    = 32,
  parameter int OUT_WIDTH    = MAC_WIDTH + 8,
  parameter int MAX_PASSES   = 64,
  parameter int SATURATE     = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        in_last,
  input  logic [ROW_WIDTH*COLUMN_WIDTH*MAC_WIDTH-1:0] maccout,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [ROW_WIDTH*OUT_WIDTH-1:0]              result,
  output logic [$clog2(MAX_PASSES+1)-1:0]             pass_count,
  output logic [ROW_WIDTH-1:0]                        sat,
  output logic                                        busy
);

  localparam int LAT_T  = (COLUMN_WIDTH > 1) ? $clog2(COLUMN_WIDTH) : 1;
  localparam int TREE_W = MAC_WIDTH + LAT_T;
  localparam int PC_W   = $clog2(MAX_PASSES + 1);

  localparam logic signed [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  function automatic int lvl_cnt(input int l);
    return (COLUMN_WIDTH + (1 << l) - 1) >> l;
  endfunction

  function automatic logic sum_ovf(input logic signed [OUT_WIDTH:0] s);
    return s[OUT_WIDTH] ^ s[OUT_WIDTH-1];
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] fit_sum(input logic signed [OUT_WIDTH:0] s);
    if ((SATURATE != 0) && sum_ovf(s))
      return s[OUT_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[OUT_WIDTH-1:0];
  endfunction

  logic                         stall;
  logic                         accept;
  logic [LAT_T-1:0]             vld_p;
  logic [LAT_T-1:0]             last_p;
  logic [ROW_WIDTH*TREE_W-1:0]  tree_sum;

  state_t                       state;
  logic [PC_W-1:0]              count_q;
  logic [PC_W-1:0]              count_next;
  logic [ROW_WIDTH-1:0]         sat_acc;
  logic [ROW_WIDTH-1:0]         sat_next;
  logic signed [OUT_WIDTH-1:0]  acc_q    [ROW_WIDTH];
  logic signed [OUT_WIDTH-1:0]  acc_next [ROW_WIDTH];
  logic signed [OUT_WIDTH-1:0]  acc_base [ROW_WIDTH];
  logic signed [OUT_WIDTH:0]    sum_ext  [ROW_WIDTH];
  logic                         close;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign busy     = (|vld_p) | (state == S_ACCUM);

  // Tree stages: level 0 is the raw slice, each later level is one register deep.
  for (genvar r = 0; r < ROW_WIDTH; r++) begin : g_row
    for (genvar l = 0; l <= LAT_T; l++) begin : g_lvl
      for (genvar k = 0; k < lvl_cnt(l); k++) begin : g_node
        logic signed [MAC_WIDTH+l-1:0] q;
        if (l == 0) begin : g_leaf
          assign q = maccout[MAC_WIDTH*(COLUMN_WIDTH*r + k) +: MAC_WIDTH];
        end else begin : g_reg
          localparam int W = MAC_WIDTH + l - 1;
          if (2*k + 1 < lvl_cnt(l-1)) begin : g_pair
            logic signed [W-1:0] a;
            logic signed [W-1:0] b;
            assign a = g_lvl[l-1].g_node[2*k].q;
            assign b = g_lvl[l-1].g_node[2*k+1].q;
            always_ff @(posedge clk) begin
              if (!stall) q <= {a[W-1], a} + {b[W-1], b};
            end
          end else begin : g_pass
            logic signed [W-1:0] a;
            assign a = g_lvl[l-1].g_node[2*k].q;
            always_ff @(posedge clk) begin
              if (!stall) q <= {a[W-1], a};
            end
          end
        end
      end
    end
    assign tree_sum[TREE_W*r +: TREE_W] = g_lvl[LAT_T].g_node[0].q;
  end

  // Beat valid and group marker ride alongside the tree levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p  <= '0;
      last_p <= '0;
    end else if (!stall) begin
      vld_p[0]  <= accept;
      last_p[0] <= in_last;
      for (int s = 1; s < LAT_T; s++) begin
        vld_p[s]  <= vld_p[s-1];
        last_p[s] <= last_p[s-1];
      end
    end
  end

  always_comb begin
    count_next = ((state == S_IDLE) ? '0 : count_q) + 1'b1;
    close      = last_p[LAT_T-1] | (count_next == PC_W'(MAX_PASSES));
    sat_next   = '0;
    for (int r = 0; r < ROW_WIDTH; r++) begin
      acc_base[r] = (state == S_IDLE) ? '0 : acc_q[r];
      sum_ext[r]  = {acc_base[r][OUT_WIDTH-1], acc_base[r]} +
                    {{(OUT_WIDTH+1-TREE_W){tree_sum[TREE_W*r+TREE_W-1]}},
                     tree_sum[TREE_W*r +: TREE_W]};
      acc_next[r] = fit_sum(sum_ext[r]);
      sat_next[r] = sum_ovf(sum_ext[r]) | ((state == S_ACCUM) & sat_acc[r]);
    end
  end

  // Accumulator / output stage: the closing beat goes straight to the result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count_q    <= '0;
      sat_acc    <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      pass_count <= '0;
      sat        <= '0;
      for (int r = 0; r < ROW_WIDTH; r++) acc_q[r] <= '0;
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (vld_p[LAT_T-1]) begin
        if (close) begin
          out_valid  <= 1'b1;
          pass_count <= count_next;
          sat        <= sat_next;
          state      <= S_IDLE;
          count_q    <= '0;
          sat_acc    <= '0;
          for (int r = 0; r < ROW_WIDTH; r++) begin
            result[OUT_WIDTH*r +: OUT_WIDTH] <= acc_next[r];
            acc_q[r] <= '0;
          end
        end else begin
          state   <= S_ACCUM;
          count_q <= count_next;
          sat_acc <= sat_next;
          for (int r = 0; r < ROW_WIDTH; r++) acc_q[r] <= acc_next[r];
        end
      end
    end
  end

endmodule
